// File: rtl/apb_irq_servicer_if.sv
// APB requester bus plus the interrupt-vector handshake driven by apb_irq_servicer.
interface apb_irq_servicer_if #(
  parameter int unsigned APB_AW = 12
);
  logic [APB_AW-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic              psel;
  logic              penable;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              vec_valid;
  logic [7:0]        vec_id;
  logic              vec_ready;

  modport master (
    output paddr, pwrite, pwdata, psel, penable, vec_valid, vec_id,
    input  prdata, pready, pslverr, vec_ready
  );

  modport slave (
    input  paddr, pwrite, pwdata, psel, penable, vec_valid, vec_id,
    output prdata, pready, pslverr, vec_ready
  );
endinterface

// File: rtl/apb_irq_servicer.sv
// Sweeps interrupt status words over APB, offers each set bit as a vector,
// then writes back exactly the serviced bits to the clear register.
module apb_irq_servicer #(
  parameter int unsigned NUM_WORDS   = 2,
  parameter int unsigned APB_AW      = 12,
  parameter int unsigned STATUS_BASE = 'h0C,
  parameter int unsigned CLR_BASE    = 'h10,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic               clk_apb,
  input  logic               rst_apb,
  input  logic               irq_in,
  apb_irq_servicer_if.master bus,
  output logic               err,
  output logic               busy
);
  localparam int unsigned WW = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SETUP, S_RD_ACCESS, S_PUSH, S_WR_SETUP, S_WR_ACCESS, S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     w_q, w_d;
  logic [DW-1:0]     snap_q, snap_d;
  logic [DW-1:0]     clr_q, clr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              timed_out;
  logic              last_w;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              vec_valid_q, vec_valid_d;
  logic [7:0]        vec_id_q, vec_id_d;
  logic              err_d;
  logic              busy_d;

  // Index of the lowest set bit; callers only use it on non-zero words.
  function automatic logic [4:0] low_bit(input logic [DW-1:0] v);
    low_bit = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) low_bit = 5'(i);
    end
  endfunction

  assign cnt_inc   = cnt_q + 8'd1;
  assign timed_out = (cnt_inc == CW'(TIMEOUT));
  assign last_w    = (32'(w_q) == NUM_WORDS - 32'd1);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    snap_d  = snap_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (irq_in) begin
          w_d     = '0;
          state_d = S_RD_SETUP;
        end
      end
      S_RD_SETUP: begin
        cnt_d   = '0;
        state_d = S_RD_ACCESS;
      end
      S_RD_ACCESS: begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end else begin
            snap_d  = bus.prdata;
            clr_d   = '0;
            state_d = (bus.prdata == '0) ? S_NEXT : S_PUSH;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end
      end
      S_PUSH: begin
        // vec_id_q[4:0] is the bit currently on offer
        if (bus.vec_ready) begin
          snap_d = snap_q & ~(32'd1 << vec_id_q[4:0]);
          clr_d  = clr_q | (32'd1 << vec_id_q[4:0]);
          if (snap_d == '0) state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_ACCESS;
      end
      S_WR_ACCESS: begin
        if (bus.pready) begin
          err_d   = bus.pslverr;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (last_w) begin
          state_d = S_IDLE;
        end else begin
          w_d     = w_q + 3'd1;
          state_d = S_RD_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from the state being entered.
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    vec_valid_d = 1'b0;
    vec_id_d    = vec_id_q;

    case (state_d)
      S_RD_SETUP, S_RD_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_RD_ACCESS);
        paddr_d   = APB_AW'(STATUS_BASE + 32'(w_d) * 32'd4);
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_WR_ACCESS);
        pwrite_d  = 1'b1;
        paddr_d   = APB_AW'(CLR_BASE + 32'(w_d) * 32'd4);
        pwdata_d  = clr_d;
      end
      S_PUSH: begin
        vec_valid_d = 1'b1;
        vec_id_d    = {w_d, low_bit(snap_d)};
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_apb) begin
    if (rst_apb) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      snap_q      <= '0;
      clr_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      vec_valid_q <= 1'b0;
      vec_id_q    <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      snap_q      <= snap_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      vec_valid_q <= vec_valid_d;
      vec_id_q    <= vec_id_d;
      err         <= err_d;
      busy        <= busy_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_id    = vec_id_q;
endmodule

// File: tb/tb_apb_irq_servicer.sv
// Bench for apb_irq_servicer: APB status/clear slave, vector consumer and
// transaction-level reference model of a full sweep.
module tb_apb_irq_servicer;
  localparam int unsigned NW   = 2;
  localparam int unsigned TMO  = 4;
  localparam int unsigned K_RD = 0;
  localparam int unsigned K_VC = 1;
  localparam int unsigned K_WR = 2;
  localparam int unsigned K_ER = 3;

  logic clk_apb = 1'b0;
  logic rst_apb;
  logic irq_in;
  logic err;
  logic busy;

  apb_irq_servicer_if #(.APB_AW(12)) bus ();

  apb_irq_servicer #(
    .NUM_WORDS(NW), .APB_AW(12), .STATUS_BASE('h0C), .CLR_BASE('h10), .TIMEOUT(TMO)
  ) dut (
    .clk_apb(clk_apb), .rst_apb(rst_apb), .irq_in(irq_in),
    .bus(bus), .err(err), .busy(busy)
  );

  always #5 clk_apb = ~clk_apb;

  typedef struct {
    int unsigned kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    bit          rerr0;
    int unsigned rwait0;
    int unsigned exp_nvec;
    int unsigned exp_nerr;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic [7:0]  exp_first;
  } tv_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int unsigned acc_len_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] status  [NW];
  logic [31:0] late    [NW];
  logic [31:0] exp_st  [NW];
  int unsigned rd_wait [NW];
  int unsigned wr_wait [NW];
  bit          rd_err  [NW];
  bit          wr_err  [NW];
  int unsigned ready_pct = 100;
  int unsigned hold_low  = 0;
  int unsigned acc_cnt   = 0;
  int unsigned acc_run   = 0;
  int unsigned vv_cnt    = 0;

  logic        prev_setup    = 1'b0;
  logic        prev_vv_stall = 1'b0;
  logic [11:0] prev_addr     = '0;
  logic        prev_wr       = 1'b0;
  logic [7:0]  prev_id       = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_apb);
    #1;
  endtask

  // Monitor, APB slave and vector consumer share one process so that the
  // handshake inputs are decided after the outputs of this cycle are logged.
  always @(negedge clk_apb) begin
    int k;
    int unsigned wt;
    if (!rst_apb) begin
      if (prev_setup) begin
        chk("setup_to_access", 32'({bus.psel, bus.penable}), 32'd3);
        chk("access_paddr", 32'(bus.paddr), 32'(prev_addr));
        chk("access_pwrite", 32'(bus.pwrite), 32'(prev_wr));
      end
      if (!bus.psel) chk("idle_bus_strobes", 32'({bus.penable, bus.pwrite}), 32'd0);
      if (prev_vv_stall && bus.vec_valid) chk("vec_id_stable", 32'(bus.vec_id), 32'(prev_id));
      if (bus.psel && !bus.penable) begin
        if (bus.pwrite) obs_q.push_back('{K_WR, 32'(bus.paddr), bus.pwdata});
        else            obs_q.push_back('{K_RD, 32'(bus.paddr), 32'd0});
      end
      if (err) obs_q.push_back('{K_ER, 32'd0, 32'd0});
      if (bus.vec_valid) vv_cnt++;
      if (bus.psel && bus.penable) acc_run++;
      else if (acc_run != 0) begin
        acc_len_q.push_back(acc_run);
        acc_run = 0;
      end
    end else begin
      acc_run = 0;
    end

    if (bus.psel && bus.penable) begin
      k = bus.pwrite ? (int'(bus.paddr) - 'h10) / 4 : (int'(bus.paddr) - 'h0C) / 4;
      if (k < 0 || k >= int'(NW)) k = 0;
      wt = bus.pwrite ? wr_wait[k] : rd_wait[k];
      if (acc_cnt >= wt) begin
        bus.pready  = 1'b1;
        bus.pslverr = bus.pwrite ? wr_err[k] : rd_err[k];
        if (!bus.pwrite) begin
          bus.prdata = status[k];
          if (!rd_err[k]) status[k] = status[k] | late[k];
        end else if (!wr_err[k]) begin
          status[k] = status[k] & ~bus.pwdata;
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt     = 0;
      bus.pready  = 1'b0;
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
    end

    if (hold_low > 0) begin
      bus.vec_ready = 1'b0;
      if (bus.vec_valid) hold_low--;
    end else begin
      bus.vec_ready = ($urandom_range(99) < ready_pct);
    end
    if (bus.vec_valid && bus.vec_ready && !rst_apb)
      obs_q.push_back('{K_VC, 32'(bus.vec_id), 32'd0});

    prev_vv_stall = bus.vec_valid && !bus.vec_ready && !rst_apb;
    prev_id       = bus.vec_id;
    prev_setup    = bus.psel && !bus.penable && !rst_apb;
    prev_addr     = bus.paddr;
    prev_wr       = bus.pwrite;
  end

  task automatic cfg_clear();
    for (int k = 0; k < int'(NW); k++) begin
      late[k]    = '0;
      rd_wait[k] = 0;
      wr_wait[k] = 0;
      rd_err[k]  = 1'b0;
      wr_err[k]  = 1'b0;
    end
    ready_pct = 100;
    hold_low  = 0;
  endtask

  // Expected transaction sequence of one sweep, from the current status words.
  task automatic build_expect();
    logic [31:0] snap;
    exp_q.delete();
    for (int k = 0; k < int'(NW); k++) begin
      snap      = status[k];
      exp_st[k] = status[k];
      exp_q.push_back('{K_RD, 32'('h0C + 4 * k), 32'd0});
      if (rd_wait[k] >= TMO || rd_err[k]) begin
        exp_q.push_back('{K_ER, 32'd0, 32'd0});
      end else begin
        exp_st[k] = snap | late[k];
        if (snap != 0) begin
          for (int b = 0; b < 32; b++)
            if (snap[b]) exp_q.push_back('{K_VC, 32'(k * 32 + b), 32'd0});
          exp_q.push_back('{K_WR, 32'('h10 + 4 * k), snap});
          if (wr_wait[k] >= TMO || wr_err[k]) exp_q.push_back('{K_ER, 32'd0, 32'd0});
          else exp_st[k] = (snap | late[k]) & ~snap;
        end
      end
    end
  endtask

  task automatic do_sweep(input string nm, input bit drop_in_push);
    int t;
    build_expect();
    obs_q.delete();
    acc_len_q.delete();
    vv_cnt = 0;
    irq_in = 1'b1;
    tick();
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
    if (!drop_in_push) irq_in = 1'b0;
    t = 0;
    while (busy && t < 3000) begin
      tick();
      if (bus.vec_valid) irq_in = 1'b0;
      t++;
    end
    irq_in = 1'b0;
    chk({nm, "_done"}, 32'(busy), 32'd0);
    repeat (3) tick();
    chk({nm, "_idle_hold"}, 32'(busy), 32'd0);
    chk({nm, "_nevents"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i].kind != exp_q[i].kind || obs_q[i].a != exp_q[i].a || obs_q[i].d != exp_q[i].d) begin
        chk($sformatf("%s_ev%0d_kind", nm, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
        chk($sformatf("%s_ev%0d_addr", nm, i), obs_q[i].a, exp_q[i].a);
        chk($sformatf("%s_ev%0d_data", nm, i), obs_q[i].d, exp_q[i].d);
      end
    end
    for (int k = 0; k < int'(NW); k++)
      chk($sformatf("%s_status%0d", nm, k), status[k], exp_st[k]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv_t tv [7];
    int unsigned nvec, nerr, t, gap;
    logic [31:0] w0, w1;
    logic [7:0]  first;

    tv[0] = '{32'h0000_0012, 32'h0, 1'b0, 0,    2,  0, 32'h12,        32'h0,         8'd1};
    tv[1] = '{32'h0,         32'h8000_0000, 1'b0, 0, 1, 0, 32'h0,     32'h8000_0000, 8'd63};
    tv[2] = '{32'h3,         32'h1, 1'b1, 0,    1,  1, 32'h0,         32'h1,         8'd32};
    tv[3] = '{32'hFFFF_FFFF, 32'h5, 1'b0, 0,    34, 0, 32'hFFFF_FFFF, 32'h5,         8'd0};
    tv[4] = '{32'h1,         32'h100, 1'b0, 1000, 1, 1, 32'h0,        32'h100,       8'd40};
    tv[5] = '{32'h0,         32'h0, 1'b0, 0,    0,  0, 32'h0,         32'h0,         8'hFF};
    tv[6] = '{32'h0000_8001, 32'h0, 1'b0, 2,    2,  0, 32'h8001,      32'h0,         8'd0};

    rst_apb = 1'b1;
    irq_in  = 1'b0;
    cfg_clear();
    status[0] = '0;
    status[1] = '0;
    repeat (3) tick();
    chk("rst_psel",      32'(bus.psel),      32'd0);
    chk("rst_penable",   32'(bus.penable),   32'd0);
    chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
    chk("rst_paddr",     32'(bus.paddr),     32'd0);
    chk("rst_pwdata",    bus.pwdata,         32'd0);
    chk("rst_vec_valid", 32'(bus.vec_valid), 32'd0);
    chk("rst_vec_id",    32'(bus.vec_id),    32'd0);
    chk("rst_err",       32'(err),           32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    rst_apb = 1'b0;
    repeat (3) tick();
    chk("idle_no_irq_busy", 32'(busy), 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 7; i++) begin
      cfg_clear();
      status[0] = tv[i].s0;
      status[1] = tv[i].s1;
      rd_err[0] = tv[i].rerr0;
      rd_wait[0] = tv[i].rwait0;
      do_sweep($sformatf("tv%0d", i), 1'b0);
      nvec = 0; nerr = 0; w0 = '0; w1 = '0; first = 8'hFF;
      for (int j = 0; j < obs_q.size(); j++) begin
        case (obs_q[j].kind)
          K_VC: begin
            if (nvec == 0) first = obs_q[j].a[7:0];
            nvec++;
          end
          K_ER: nerr++;
          K_WR: begin
            if (obs_q[j].a == 32'h10) w0 = obs_q[j].d;
            if (obs_q[j].a == 32'h14) w1 = obs_q[j].d;
          end
          default: ;
        endcase
      end
      chk($sformatf("tv%0d_nvec", i), 32'(nvec), 32'(tv[i].exp_nvec));
      chk($sformatf("tv%0d_nerr", i), 32'(nerr), 32'(tv[i].exp_nerr));
      chk($sformatf("tv%0d_clr0", i), w0, tv[i].exp_w0);
      chk($sformatf("tv%0d_clr1", i), w1, tv[i].exp_w1);
      chk($sformatf("tv%0d_first_vec", i), 32'(first), 32'(tv[i].exp_first));
    end

    // Consumer stalls five cycles on vector 63
    cfg_clear();
    status[0] = 32'h0;
    status[1] = 32'h8000_0000;
    hold_low  = 5;
    do_sweep("stall", 1'b0);
    chk("stall_valid_cycles", 32'(vv_cnt), 32'd6);

    // Read of word0 never completes
    cfg_clear();
    status[0] = 32'h1;
    status[1] = 32'h2;
    rd_wait[0] = 1000;
    do_sweep("timeout", 1'b0);
    chk("timeout_nruns", 32'(acc_len_q.size() > 0), 32'd1);
    if (acc_len_q.size() > 0) chk("timeout_access_len", 32'(acc_len_q[0]), TMO);

    // Reset lands in the middle of the clear write
    cfg_clear();
    status[0] = 32'h3;
    status[1] = 32'h0;
    wr_wait[0] = 1000;
    irq_in = 1'b1;
    t = 0;
    while (!(bus.psel && bus.penable && bus.pwrite) && t < 200) begin
      tick();
      t++;
    end
    chk("reset_reached_wr_access", 32'(bus.psel && bus.penable && bus.pwrite), 32'd1);
    tick();
    rst_apb = 1'b1;
    irq_in  = 1'b0;
    tick();
    chk("reset_mid_psel",      32'(bus.psel),      32'd0);
    chk("reset_mid_penable",   32'(bus.penable),   32'd0);
    chk("reset_mid_busy",      32'(busy),          32'd0);
    chk("reset_mid_vec_valid", 32'(bus.vec_valid), 32'd0);
    rst_apb = 1'b0;
    wr_wait[0] = 0;
    tick();
    chk("reset_no_clear", status[0], 32'h3);
    do_sweep("after_reset", 1'b0);

    // irq_in drops while word0 vectors are being offered
    cfg_clear();
    status[0] = 32'h6;
    status[1] = 32'h1;
    ready_pct = 60;
    do_sweep("irq_drop", 1'b1);

    // irq_in held high across the end of a sweep
    cfg_clear();
    status[0] = 32'h1;
    status[1] = 32'h0;
    irq_in = 1'b1;
    tick();
    t = 0;
    while (busy && t < 500) begin
      tick();
      t++;
    end
    chk("rearm_first_done", 32'(busy), 32'd0);
    gap = 0;
    while (!busy && gap < 10) begin
      tick();
      gap++;
    end
    chk("rearm_idle_gap", 32'(gap >= 1 && gap < 10), 32'd1);
    irq_in = 1'b0;
    t = 0;
    while (busy && t < 500) begin
      tick();
      t++;
    end
    chk("rearm_second_done", 32'(busy), 32'd0);
    repeat (2) tick();

    // Randomized sweeps against the reference model
    for (int i = 0; i < 40; i++) begin
      cfg_clear();
      for (int k = 0; k < int'(NW); k++) begin
        status[k]  = $urandom & $urandom & $urandom;
        if ($urandom_range(7) == 0) status[k] = '0;
        late[k]    = $urandom & $urandom;
        rd_wait[k] = ($urandom_range(9) == 0) ? 1000 : $urandom_range(2);
        rd_err[k]  = ($urandom_range(7) == 0);
        wr_wait[k] = ($urandom_range(9) == 0) ? 1000 : $urandom_range(2);
        wr_err[k]  = ($urandom_range(7) == 0);
      end
      ready_pct = $urandom_range(100, 30);
      do_sweep($sformatf("rnd%0d", i), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_irq_servicer.md
APB_IRQ_SERVICER -- requirements
Module: apb_irq_servicer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 2, number of 32-bit interrupt status words serviced (1..8).
REQ-002 SHALL have parameter APB_AW, default 12, APB address width.
REQ-003 SHALL have parameter STATUS_BASE, default 'h0C, address of status word 0; word k is at STATUS_BASE+4*k.
REQ-004 SHALL have parameter CLR_BASE, default 'h10, address of clear word 0; word k is at CLR_BASE+4*k.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum ACCESS-phase cycles without pready (1..255).
REQ-006 SHALL have the following ports:
clk_apb  in  1  sole clock; all logic on its rising edge.
rst_apb  in  1  synchronous, active-high reset.
irq_in  in  1  level interrupt request from the aggregator global output.
paddr  out  APB_AW  APB address.
pwrite  out  1  APB write strobe.
pwdata  out  32  APB write data.
psel  out  1  APB select.
penable  out  1  APB enable.
prdata  in  32  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB error.
vec_valid  out  1  interrupt vector offered.
vec_id  out  8  vector number: word*32 + bit.
vec_ready  in  1  consumer accepts vector.
err  out  1  one-cycle pulse on pslverr or timeout.
busy  out  1  high whenever state is not IDLE.

Function
REQ-007 SHALL implement states IDLE, RD_SETUP, RD_ACCESS, PUSH, WR_SETUP, WR_ACCESS, NEXT; all outputs registered.
REQ-008 IDLE: if irq_in=1, SHALL set word index w=0 and go to RD_SETUP; otherwise remain.
REQ-009 RD_SETUP: psel=1, penable=0, pwrite=0, paddr=STATUS_BASE+4*w, held one cycle, then RD_ACCESS.
REQ-010 RD_ACCESS: psel=1, penable=1, same paddr; held until pready=1 or timeout.
REQ-011 On pready=1 with pslverr=0 SHALL capture prdata into snap and clr_mask=0; snap=0 -> NEXT, else PUSH.
REQ-012 On pready=1 with pslverr=1 SHALL pulse err for one cycle, discard data, and go to NEXT.
REQ-013 An 8-bit wait counter SHALL clear on entry to each ACCESS state, increment each ACCESS cycle with pready=0, and when it reaches TIMEOUT SHALL pulse err, deassert psel/penable, and go to NEXT.
REQ-014 PUSH: vec_valid=1, vec_id=w*32+index of lowest set bit of snap; vec_id SHALL be stable while vec_valid=1 and vec_ready=0.
REQ-015 On vec_valid&vec_ready SHALL clear that bit in snap and set it in clr_mask; if snap becomes 0 go to WR_SETUP with vec_valid=0, else offer the next-lowest bit the following cycle.
REQ-016 WR_SETUP: psel=1, penable=0, pwrite=1, paddr=CLR_BASE+4*w, pwdata=clr_mask, one cycle, then WR_ACCESS.
REQ-017 WR_ACCESS: psel=1, penable=1, pwrite=1, held until pready or timeout; pslverr or timeout SHALL pulse err; then NEXT.
REQ-018 NEXT: psel=0, penable=0; if w=NUM_WORDS-1 go to IDLE, else w=w+1 and go to RD_SETUP.
REQ-019 Outside SETUP/ACCESS states psel, penable, and pwrite SHALL be 0; paddr and pwdata hold their last value.
REQ-020 irq_in SHALL be sampled only in IDLE; deassertion mid-sweep SHALL NOT abort the sweep.
REQ-021 After returning to IDLE, at least one IDLE cycle SHALL elapse before a new sweep.
REQ-022 Bits set in hardware status after the snapshot SHALL NOT be cleared; only clr_mask bits are written.

Reset
REQ-023 With rst_apb=1 at a clock edge: state=IDLE, w=0, snap=0, clr_mask=0, counter=0; psel, penable, pwrite, vec_valid, err, busy=0; paddr=0, pwdata=0, vec_id=0.
REQ-024 Reset asserted mid-transfer or mid-PUSH SHALL drop psel and vec_valid at that edge; no clear write is issued.

Verification
REQ-025 NUM_WORDS=2, irq_in=1, word0 reads 0x0000_0012, word1 reads 0 -> vec_id 1 then 4; write 0x12 to 'h10; read 'h10 (word1); return to IDLE; busy low.
REQ-026 Word1 reads 0x8000_0000, vec_ready held low 5 cycles -> vec_id=63 stable for all 6 cycles; clear write 0x8000_0000 to 'h14.
REQ-027 pslverr=1 on the word0 read -> err pulse of 1 cycle, no PUSH or clear for word0, word1 read follows.
REQ-028 TIMEOUT=4, pready stuck 0 on read -> psel drops after 4 ACCESS cycles, err pulses, sweep continues to word1.
REQ-029 rst_apb asserted during WR_ACCESS -> next cycle psel=0, busy=0, vec_valid=0; after release, irq_in=1 restarts from word0.
REQ-030 irq_in drops during PUSH of word0 -> sweep completes both words; IDLE is held while irq_in=0.
